// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encoding and the default cache-miss watchdog threshold.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FROZEN = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int MISS_TIMEOUT_DEF = 200;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between hazard detection + caches and the
// pipeline controller.
// Handshake: there is none. Requests are level signals sampled by the
// controller every cycle; controls are combinational responses that are
// valid in the same cycle and must be used by the pipeline registers at
// the next rising clock edge.
// master: hazard unit / caches / pipeline registers (drive requests, use controls)
// slave : the stall controller (uses requests, drives controls)
interface pipe_stall_ctrl_if;

  // requests
  logic stall_mem;
  logic stall_br;
  logic branch_taken;
  logic imem_miss;
  logic dmem_miss;
  logic halt_MW;

  // controls
  logic pc_we;
  logic pc_sel_br;
  logic fd_we;
  logic fd_flush;
  logic dx_we;
  logic dx_bubble;
  logic xm_we;
  logic mw_we;
  logic halted;
  logic err_timeout;

  modport master (
    output stall_mem, stall_br, branch_taken, imem_miss, dmem_miss, halt_MW,
    input  pc_we, pc_sel_br, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we,
    input  halted, err_timeout
  );

  modport slave (
    input  stall_mem, stall_br, branch_taken, imem_miss, dmem_miss, halt_MW,
    output pc_we, pc_sel_br, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we,
    output halted, err_timeout
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Used for the freeze watchdog and the optional performance counters.
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // count up, hold at all-ones, clear on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/halt controller for the 5-stage pipe.
// Priority: HALTED > dmem_miss > hazard stall > imem_miss > branch redirect
// (a redirect still applies on top of imem_miss). Controls are Mealy
// outputs and are forced to 0 while rst_n is low.
// Optional feature macro: STALL_PERF_CNT_EN adds perf_stall_cyc,
// perf_frz_cyc and perf_flush_cnt saturating counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W    = 8,
  parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stall_ctrl_if.slave     bus,
  output state_e               o_dbg_state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     perf_stall_cyc,
  output logic [CNT_W-1:0]     perf_frz_cyc,
  output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);

  // err_timeout is raised on the same edge that frz_cnt reaches MISS_TIMEOUT
  localparam logic [TIMEOUT_W-1:0] LP_ERR_AT = TIMEOUT_W'(MISS_TIMEOUT - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_pending_br;
  logic                 r_err;
  logic [TIMEOUT_W-1:0] w_frz_cnt;
  logic                 w_any_miss;
  logic                 w_set_pend;
  logic                 w_redirect;
  logic                 w_pc_we, w_pc_sel_br, w_fd_we, w_fd_flush;
  logic                 w_dx_we, w_dx_bubble, w_xm_we, w_mw_we, w_halted;

  assign w_any_miss = bus.imem_miss | bus.dmem_miss;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // next state and per-stage controls, highest priority first
  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_pc_sel_br = 1'b0;
    w_fd_we     = 1'b0;
    w_fd_flush  = 1'b0;
    w_dx_we     = 1'b0;
    w_dx_bubble = 1'b0;
    w_xm_we     = 1'b0;
    w_mw_we     = 1'b0;
    w_halted    = 1'b0;
    w_set_pend  = 1'b0;
    w_redirect  = 1'b0;
    if (r_state == ST_HALTED) begin
      w_halted = 1'b1;
    end else if (bus.dmem_miss) begin
      // full freeze; a resolved branch is parked until the pipe thaws
      w_state_nxt = ST_FROZEN;
      w_set_pend  = bus.branch_taken & ~bus.stall_br;
    end else if (bus.halt_MW) begin
      // let the HLT retire, nothing else moves
      w_state_nxt = ST_HALTED;
      w_mw_we     = 1'b1;
    end else begin
      w_state_nxt = ST_RUN;
      w_dx_we     = 1'b1;
      w_xm_we     = 1'b1;
      w_mw_we     = 1'b1;
      if (bus.stall_mem || bus.stall_br) begin
        w_dx_bubble = 1'b1;
      end else if (bus.branch_taken || r_pending_br) begin
        w_redirect  = 1'b1;
        w_pc_we     = 1'b1;
        w_pc_sel_br = 1'b1;
        w_fd_we     = 1'b1;
        w_fd_flush  = 1'b1;
      end else if (bus.imem_miss) begin
        w_fd_we    = 1'b1;
        w_fd_flush = 1'b1;
      end else begin
        w_pc_we = 1'b1;
        w_fd_we = 1'b1;
      end
    end
  end

  // remembered branch redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pending_br <= 1'b0;
    else if (w_redirect) r_pending_br <= 1'b0;
    else if (w_set_pend) r_pending_br <= 1'b1;
  end

  pipe_stall_ctrl_sat_counter #(.W(TIMEOUT_W)) u_frz_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_any_miss),
    .i_clr (~w_any_miss),
    .o_q   (w_frz_cnt)
  );

  // sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_err <= 1'b0;
    else if (w_any_miss && w_frz_cnt >= LP_ERR_AT) r_err <= 1'b1;
  end

  assign bus.pc_we       = rst_n & w_pc_we;
  assign bus.pc_sel_br   = rst_n & w_pc_sel_br;
  assign bus.fd_we       = rst_n & w_fd_we;
  assign bus.fd_flush    = rst_n & w_fd_flush;
  assign bus.dx_we       = rst_n & w_dx_we;
  assign bus.dx_bubble   = rst_n & w_dx_bubble;
  assign bus.xm_we       = rst_n & w_xm_we;
  assign bus.mw_we       = rst_n & w_mw_we;
  assign bus.halted      = rst_n & w_halted;
  assign bus.err_timeout = rst_n & r_err;
  assign o_dbg_state     = r_state;

`ifdef STALL_PERF_CNT_EN
  logic w_hz_stall;
  logic w_dm_frz;

  assign w_hz_stall = (r_state != ST_HALTED) & ~bus.dmem_miss & ~bus.halt_MW &
                      (bus.stall_mem | bus.stall_br);
  assign w_dm_frz   = (r_state != ST_HALTED) & bus.dmem_miss;

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_perf_stall (
    .clk(clk), .rst_n(rst_n), .i_inc(w_hz_stall), .i_clr(1'b0), .o_q(perf_stall_cyc)
  );
  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_perf_frz (
    .clk(clk), .rst_n(rst_n), .i_inc(w_dm_frz), .i_clr(1'b0), .o_q(perf_frz_cyc)
  );
  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_perf_flush (
    .clk(clk), .rst_n(rst_n), .i_inc(w_redirect), .i_clr(1'b0), .o_q(perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: per-cycle stimulus with hand-derived expected
// control vectors queued in a scoreboard and compared mid-cycle.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 10;

  // input vector: {stall_mem, stall_br, branch_taken, imem_miss, dmem_miss, halt_MW}
  localparam logic [5:0] I_IDLE = 6'b000000;
  localparam logic [5:0] I_SMEM = 6'b100000;
  localparam logic [5:0] I_SBR  = 6'b010000;
  localparam logic [5:0] I_BT   = 6'b001000;
  localparam logic [5:0] I_IM   = 6'b000100;
  localparam logic [5:0] I_DM   = 6'b000010;
  localparam logic [5:0] I_HLT  = 6'b000001;

  // output vector: {pc_we, pc_sel_br, fd_we, fd_flush, dx_we, dx_bubble,
  //                 xm_we, mw_we, halted, err_timeout}
  localparam logic [9:0] E_ZERO  = 10'b00_0000_0000;
  localparam logic [9:0] E_IDLE  = 10'b10_1010_1100;
  localparam logic [9:0] E_STALL = 10'b00_0011_1100;
  localparam logic [9:0] E_BR    = 10'b11_1110_1100;
  localparam logic [9:0] E_IMISS = 10'b00_1110_1100;
  localparam logic [9:0] E_HENT  = 10'b00_0000_0100;
  localparam logic [9:0] E_HALT  = 10'b00_0000_0010;
  localparam logic [9:0] E_ERR   = 10'b00_0000_0001;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;
  int     n_checks = 0;
  int     n_fail   = 0;
  logic [9:0] exp_q[$];

`ifdef STALL_PERF_CNT_EN
  logic [15:0] perf_stall_cyc, perf_frz_cyc, perf_flush_cnt;
`endif

  // clock / reset
  always #5 clk = ~clk;

  pipe_stall_ctrl_if u_if ();

  pipe_stall_ctrl #(
    .TIMEOUT_W    (8),
    .MISS_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (u_if.slave),
    .o_dbg_state    (dbg_state)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_frz_cyc   (perf_frz_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {u_if.pc_we, u_if.pc_sel_br, u_if.fd_we, u_if.fd_flush, u_if.dx_we,
            u_if.dx_bubble, u_if.xm_we, u_if.mw_we, u_if.halted, u_if.err_timeout};
  endfunction

  // driver: apply one cycle of inputs, queue the expectation, compare mid-cycle
  task automatic step(input string tag, input logic rst, input logic [5:0] in,
                      input logic [9:0] exp);
    logic [9:0] e;
    @(posedge clk);
    #1;
    rst_n = rst;
    {u_if.stall_mem, u_if.stall_br, u_if.branch_taken,
     u_if.imem_miss, u_if.dmem_miss, u_if.halt_MW} = in;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {6'b0, obs_vec()}, {6'b0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {u_if.stall_mem, u_if.stall_br, u_if.branch_taken,
     u_if.imem_miss, u_if.dmem_miss, u_if.halt_MW} = I_IDLE;

    step("reset", 1'b0, I_IDLE, E_ZERO);
    step("reset_rel", 1'b1, I_IDLE, E_IDLE);
    chk("st_run", {14'b0, dbg_state}, {14'b0, ST_RUN});

    // hazard stalls
    step("load_use", 1'b1, I_SMEM, E_STALL);
    step("after_lu", 1'b1, I_IDLE, E_IDLE);
    step("stall_br", 1'b1, I_SBR, E_STALL);

    // plain branch and instruction misses
    step("branch", 1'b1, I_BT, E_BR);
    step("after_br", 1'b1, I_IDLE, E_IDLE);
    step("imiss", 1'b1, I_IM, E_IMISS);
    step("imiss_br", 1'b1, I_IM | I_BT, E_BR);
    step("imiss_lu", 1'b1, I_IM | I_SMEM, E_STALL);
    step("idle1", 1'b1, I_IDLE, E_IDLE);

    // branch resolved during a data-cache freeze
    step("frz1", 1'b1, I_DM, E_ZERO);
    step("frz2_br", 1'b1, I_DM | I_BT, E_ZERO);
    chk("st_frozen", {14'b0, dbg_state}, {14'b0, ST_FROZEN});
    step("frz3", 1'b1, I_DM, E_ZERO);
    step("frz4", 1'b1, I_DM, E_ZERO);
    step("frz5", 1'b1, I_DM, E_ZERO);
    step("thaw_redir", 1'b1, I_IDLE, E_BR);
    step("thaw_next", 1'b1, I_IDLE, E_IDLE);

    // stall_br beats imem_miss and branch_taken
    step("conflict", 1'b1, I_SBR | I_IM | I_BT, E_STALL);
    step("conflict_nx", 1'b1, I_IDLE, E_IDLE);

    // dmem_miss blocks halt entry and ignores branch under stall_br
    step("dm_halt", 1'b1, I_DM | I_SMEM | I_HLT, E_ZERO);
    step("dm_halt_nx", 1'b1, I_IDLE, E_IDLE);
    step("dm_sbr_br", 1'b1, I_DM | I_SBR | I_BT, E_ZERO);
    step("dm_sbr_nx", 1'b1, I_IDLE, E_IDLE);

    // reset while frozen with a parked branch
    step("mid_frz1", 1'b1, I_DM | I_BT, E_ZERO);
    step("mid_frz2", 1'b1, I_DM, E_ZERO);
    step("mid_rst", 1'b0, I_DM, E_ZERO);
    step("mid_rel", 1'b1, I_IDLE, E_IDLE);
    chk("st_run2", {14'b0, dbg_state}, {14'b0, ST_RUN});

    // watchdog on a long instruction miss
    for (int k = 1; k <= 12; k++) begin
      step($sformatf("wdog%0d", k), 1'b1, I_IM, (k <= TB_TIMEOUT) ? E_IMISS : (E_IMISS | E_ERR));
    end
    step("wdog_sticky1", 1'b1, I_IDLE, E_IDLE | E_ERR);
    step("wdog_sticky2", 1'b1, I_IDLE, E_IDLE | E_ERR);
`ifdef STALL_PERF_CNT_EN
    chk("perf_frz", perf_frz_cyc, 16'd0);
`endif

    // halt
    step("halt_enter", 1'b1, I_HLT, E_HENT | E_ERR);
    for (int k = 0; k < 6; k++) begin
      step("halted", 1'b1, 6'($urandom_range(0, 63)), E_HALT | E_ERR);
    end
    chk("st_halted", {14'b0, dbg_state}, {14'b0, ST_HALTED});

    // reset leaves HALTED
    step("final_rst", 1'b0, I_SMEM | I_DM, E_ZERO);
    step("final_rel", 1'b1, I_IDLE, E_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
